// File: rtl/ex_stage.sv
// Execute stage: ID/EX pipeline register, operand select, ALU,
// data SRAM request generation and EX-stage forwarding.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         ex_wreg,
  output logic [4:0]   ex_waddr,
  output logic [31:0]  ex_wdata,
  output logic         ex_opl
);

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  logic [158:0] id_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex <= '0;
    end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
      id_ex <= '0;
    end else if (stall[2] == NO_STOP) begin
      id_ex <= id_to_ex_bus;
    end
  end

  logic [31:0] pc, inst, rs_val, rt_val;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2;
  logic        ram_en, rf_we, sel_rf_res;
  logic [3:0]  ram_code;
  logic [4:0]  rf_waddr;

  assign pc         = id_ex[158:127];
  assign inst       = id_ex[126:95];
  assign alu_op     = id_ex[94:83];
  assign sel_src1   = id_ex[82:80];
  assign sel_src2   = id_ex[79:76];
  assign ram_en     = id_ex[75];
  assign ram_code   = id_ex[74:71];
  assign rf_we      = id_ex[70];
  assign rf_waddr   = id_ex[69:65];
  assign sel_rf_res = id_ex[64];
  assign rs_val     = id_ex[63:32];
  assign rt_val     = id_ex[31:0];

  logic unused_bits;
  assign unused_bits = ^{inst[31:16], stall[5:4], stall[1:0]};

  logic [31:0] src1, src2, result;

  always_comb begin
    src1 = '0;
    unique case (1'b1)
      sel_src1[0]: src1 = rs_val;
      sel_src1[1]: src1 = pc;
      sel_src1[2]: src1 = {27'b0, inst[10:6]};
      default:     src1 = '0;
    endcase
  end

  always_comb begin
    src2 = '0;
    unique case (1'b1)
      sel_src2[0]: src2 = rt_val;
      sel_src2[1]: src2 = {{16{inst[15]}}, inst[15:0]};
      sel_src2[2]: src2 = 32'd8;
      sel_src2[3]: src2 = {16'b0, inst[15:0]};
      default:     src2 = '0;
    endcase
  end

  always_comb begin
    result = '0;
    unique case (1'b1)
      alu_op[0]:  result = src1 + src2;
      alu_op[1]:  result = src1 - src2;
      alu_op[2]:  result = {31'b0, $signed(src1) < $signed(src2)};
      alu_op[3]:  result = {31'b0, src1 < src2};
      alu_op[4]:  result = src1 & src2;
      alu_op[5]:  result = ~(src1 | src2);
      alu_op[6]:  result = src1 | src2;
      alu_op[7]:  result = src1 ^ src2;
      alu_op[8]:  result = src2 << src1[4:0];
      alu_op[9]:  result = src2 >> src1[4:0];
      alu_op[10]: result = $unsigned($signed(src2) >>> src1[4:0]);
      alu_op[11]: result = {src2[15:0], 16'b0};
      default:    result = '0;
    endcase
  end

  logic is_sw, is_sb, is_sh, is_store, rf_we_eff;

  assign is_sw     = ram_en & (ram_code == 4'b1111);
  assign is_sb     = ram_en & (ram_code == 4'b0001);
  assign is_sh     = ram_en & (ram_code == 4'b0011);
  assign is_store  = is_sw | is_sb | is_sh;
  assign rf_we_eff = rf_we & ~is_store;

  always_comb begin
    data_sram_wen   = 4'b0000;
    data_sram_wdata = '0;
    unique case (1'b1)
      is_sw: begin
        data_sram_wen   = 4'b1111;
        data_sram_wdata = rt_val;
      end
      is_sb: begin
        data_sram_wen   = 4'b0001 << result[1:0];
        data_sram_wdata = {4{rt_val[7:0]}};
      end
      is_sh: begin
        data_sram_wen   = result[1] ? 4'b1100 : 4'b0011;
        data_sram_wdata = {2{rt_val[15:0]}};
      end
      default: begin
        data_sram_wen   = 4'b0000;
        data_sram_wdata = '0;
      end
    endcase
  end

  assign data_sram_en   = ram_en;
  assign data_sram_addr = result;

  assign ex_to_mem_bus = {pc, ram_en, ram_code, sel_rf_res,
                          rf_we_eff, rf_waddr, result};

  assign ex_wreg  = rf_we_eff;
  assign ex_waddr = rf_waddr;
  assign ex_wdata = result;
  assign ex_opl   = ram_en & sel_rf_res & rf_we_eff;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed scenarios plus random traffic
// against a field-level reference model of the execute stage.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_wreg;
  logic [4:0]   ex_waddr;
  logic [31:0]  ex_wdata;
  logic         ex_opl;

  ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall),
    .id_to_ex_bus(id_to_ex_bus), .ex_to_mem_bus(ex_to_mem_bus),
    .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata),
    .ex_wreg(ex_wreg), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata),
    .ex_opl(ex_opl)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [158:0] mreg;
  logic [75:0]  e_bus;
  logic         e_en, e_wreg, e_opl;
  logic [3:0]   e_wen;
  logic [31:0]  e_addr, e_wdata, e_res;
  logic [4:0]   e_waddr;

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst,
    input logic [11:0] op, input logic [2:0] s1,
    input logic [3:0] s2, input logic ren,
    input logic [3:0] code, input logic we,
    input logic [4:0] wa, input logic selres,
    input logic [31:0] rs, input logic [31:0] rt);
    return {pc, inst, op, s1, s2, ren, code, we, wa, selres, rs, rt};
  endfunction

  task automatic model();
    logic [31:0] pc, inst, rs, rt, a, b, r;
    logic [11:0] op;
    logic [2:0]  s1;
    logic [3:0]  s2, code;
    logic        ren, we, selres, st;
    int          sh;
    pc = mreg[158:127]; inst = mreg[126:95]; op = mreg[94:83];
    s1 = mreg[82:80]; s2 = mreg[79:76]; ren = mreg[75];
    code = mreg[74:71]; we = mreg[70]; selres = mreg[64];
    rs = mreg[63:32]; rt = mreg[31:0];
    a = 0; b = 0; r = 0;
    if (s1 == 3'b001) a = rs;
    if (s1 == 3'b010) a = pc;
    if (s1 == 3'b100) a = inst[10:6];
    if (s2 == 4'b0001) b = rt;
    if (s2 == 4'b0010) b = inst[15] ? inst[15:0] + 32'hFFFF0000
                                    : {16'h0, inst[15:0]};
    if (s2 == 4'b0100) b = 8;
    if (s2 == 4'b1000) b = {16'h0, inst[15:0]};
    sh = a % 32;
    for (int i = 0; i < 12; i++) if (op == (12'd1 << i)) begin
      case (i)
        0: r = a + b;
        1: r = a - b;
        2: r = ((a ^ 32'h80000000) < (b ^ 32'h80000000)) ? 1 : 0;
        3: r = (a < b) ? 1 : 0;
        4: r = a & b;
        5: r = ~(a | b);
        6: r = a | b;
        7: r = a ^ b;
        8: r = b << sh;
        9: r = b >> sh;
        10: r = b[31] ? ((b >> sh) | ~(32'hFFFFFFFF >> sh)) : b >> sh;
        default: r = b * 65536;
      endcase
    end
    e_res = r; e_addr = r; e_en = ren;
    e_wen = 0; e_wdata = 0; st = 0;
    if (ren && code == 4'hF) begin
      st = 1; e_wen = 4'hF; e_wdata = rt;
    end
    if (ren && code == 4'h1) begin
      st = 1; e_wen[r % 4] = 1'b1;
      e_wdata = rt[7:0] * 32'h01010101;
    end
    if (ren && code == 4'h3) begin
      st = 1; e_wen = (r % 4 >= 2) ? 4'b1100 : 4'b0011;
      e_wdata = rt[15:0] * 32'h00010001;
    end
    e_wreg = we && !st;
    e_waddr = mreg[69:65];
    e_opl = ren && selres && e_wreg;
    e_bus = {pc, ren, code, selres, e_wreg, e_waddr, r};
  endtask

  task automatic chk(input string tag, input logic [75:0] got,
                     input logic [75:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    model();
    chk("bus", ex_to_mem_bus, e_bus);
    chk("en", 76'(data_sram_en), 76'(e_en));
    chk("wen", 76'(data_sram_wen), 76'(e_wen));
    chk("addr", 76'(data_sram_addr), 76'(e_addr));
    chk("wdata", 76'(data_sram_wdata), 76'(e_wdata));
    chk("wreg", 76'(ex_wreg), 76'(e_wreg));
    chk("waddr", 76'(ex_waddr), 76'(e_waddr));
    chk("fwd", 76'(ex_wdata), 76'(e_res));
    chk("opl", 76'(ex_opl), 76'(e_opl));
  endtask

  task automatic step(input logic r, input logic [5:0] s,
                      input logic [158:0] bus);
    rst = r; stall = s; id_to_ex_bus = bus;
    @(posedge clk);
    if (r) mreg = 0;
    else if (s[2] && !s[3]) mreg = 0;
    else if (!s[2]) mreg = bus;
    #1;
    check_all();
  endtask

  localparam logic [11:0] ADD = 12'd1;
  logic [158:0] addu, jal, sb, lw, shw, sw, rb;

  initial begin
    rst = 1; stall = 0; id_to_ex_bus = 0; mreg = 0;
    addu = mk(32'h100, 0, ADD, 3'b001, 4'b0001, 0, 0, 1, 5, 0,
              32'hFFFFFFFF, 2);
    jal  = mk(32'hBFC00010, 0, ADD, 3'b010, 4'b0100, 0, 0, 1, 31, 0,
              0, 0);
    sb   = mk(32'h200, 32'h0002, ADD, 3'b001, 4'b0010, 1, 4'b0001,
              1, 3, 0, 32'h1003, 32'h123456AB);
    lw   = mk(32'h204, 32'h0004, ADD, 3'b001, 4'b0010, 1, 4'b0000,
              1, 8, 1, 32'h2000, 0);
    shw  = mk(32'h208, 32'h0002, ADD, 3'b001, 4'b0010, 1, 4'b0011,
              0, 0, 0, 32'h2000, 32'hBEEF1234);
    sw   = mk(32'h20C, 32'h0001, ADD, 3'b001, 4'b0010, 1, 4'b1111,
              0, 0, 0, 32'h3000, 32'hCAFEF00D);

    step(1, 6'b001100, addu);
    chk("rst_bus", ex_to_mem_bus, 76'd0);

    step(0, 0, addu);
    chk("addu_res", 76'(ex_wdata), 76'd1);
    chk("addu_wreg", 76'(ex_wreg), 76'd1);
    chk("addu_waddr", 76'(ex_waddr), 76'd5);
    chk("addu_opl", 76'(ex_opl), 76'd0);

    step(0, 0, jal);
    chk("jal_res", 76'(ex_wdata), 76'hBFC00018);

    step(0, 0, sb);
    chk("sb_addr", 76'(data_sram_addr), 76'h1005);
    chk("sb_wen", 76'(data_sram_wen), 76'b0010);
    chk("sb_wdata", 76'(data_sram_wdata), 76'hABABABAB);
    chk("sb_wreg", 76'(ex_wreg), 76'd0);

    step(0, 0, lw);
    chk("lw_en", 76'(data_sram_en), 76'd1);
    chk("lw_wen", 76'(data_sram_wen), 76'd0);
    chk("lw_opl", 76'(ex_opl), 76'd1);
    step(0, 6'b000100, jal);
    chk("bubble_bus", ex_to_mem_bus, 76'd0);
    chk("bubble_en", 76'(data_sram_en), 76'd0);

    step(0, 0, shw);
    for (int i = 0; i < 3; i++) begin
      step(0, 6'b001100, addu);
      chk("hold_wen", 76'(data_sram_wen), 76'b1100);
      chk("hold_en", 76'(data_sram_en), 76'd1);
      chk("hold_wdata", 76'(data_sram_wdata), 76'h12341234);
    end
    step(0, 0, addu);
    chk("release_res", 76'(ex_wdata), 76'd1);

    step(0, 0, sw);
    chk("sw_wen", 76'(data_sram_wen), 76'hF);
    step(0, 6'b001100, addu);
    step(1, 6'b001100, addu);
    chk("rst_en", 76'(data_sram_en), 76'd0);
    chk("rst_wen", 76'(data_sram_wen), 76'd0);
    chk("rst_bus2", ex_to_mem_bus, 76'd0);

    for (int i = 0; i < 300; i++) begin
      int ai, s1i, s2i, ci;
      logic [3:0] code;
      logic [5:0] s;
      ai = $urandom_range(0, 12);
      s1i = $urandom_range(0, 3);
      s2i = $urandom_range(0, 4);
      ci = $urandom_range(0, 3);
      code = (ci == 0) ? 4'hF : (ci == 1) ? 4'h1 :
             (ci == 2) ? 4'h3 : 4'($urandom);
      rb = mk($urandom, $urandom,
              (ai == 12) ? 12'd0 : 12'd1 << ai,
              (s1i == 3) ? 3'd0 : 3'd1 << s1i,
              (s2i == 4) ? 4'd0 : 4'd1 << s2i,
              1'($urandom), code, 1'($urandom), 5'($urandom),
              1'($urandom), $urandom, $urandom);
      s = 6'($urandom);
      if ($urandom_range(0, 2) != 0) s[3:2] = 2'b00;
      step($urandom_range(0, 30) == 0, s, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
